// File: rtl/ddc_accum.sv
// Integrate-and-dump accumulator for the {Q, I} DDC stream, feeding a FWFT FIFO on an AXI4-Stream master.
// Optional macro DDC_ACCUM_FRAME_SEQ_EN adds m_axis_tuser, a per-frame sequence number that counts dropped frames too.
module ddc_accum #(
  parameter int IN_W       = 32,
  parameter int ACC_W      = 48,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [LEN_W-1:0]     acc_len,
  input  logic                 valid_in,
  input  logic [2*IN_W-1:0]    data_in,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [2*ACC_W-1:0]   m_axis_tdata,
`ifdef DDC_ACCUM_FRAME_SEQ_EN
  output logic [31:0]          m_axis_tuser,
`endif
  output logic                 overflow,
  output logic [15:0]          drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef DDC_ACCUM_FRAME_SEQ_EN
  localparam int FW = 2*ACC_W + 32;
`else
  localparam int FW = 2*ACC_W;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_sel;
  logic [ACC_W-1:0] acc_i;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sext_i;
  logic [ACC_W-1:0] sext_q;
  logic [ACC_W-1:0] sum_i;
  logic [ACC_W-1:0] sum_q;
  logic             last_sample;

  logic start;
  logic accumulate;
  logic complete;
  logic discard;

  assign len_sel     = (acc_len == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : acc_len;
  assign sext_i      = {{(ACC_W-IN_W){data_in[IN_W-1]}}, data_in[IN_W-1:0]};
  assign sext_q      = {{(ACC_W-IN_W){data_in[2*IN_W-1]}}, data_in[2*IN_W-1:IN_W]};
  assign sum_i       = acc_i + sext_i;
  assign sum_q       = acc_q + sext_q;
  assign last_sample = (cnt == len_r - {{(LEN_W-1){1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    accumulate = 1'b0;
    complete   = 1'b0;
    discard    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nx = ACCUM;
          start    = 1'b1;
        end
      end
      ACCUM: begin
        if (!en) begin
          state_nx = IDLE;
          discard  = 1'b1;
        end else if (valid_in) begin
          if (last_sample) begin
            complete = 1'b1;
          end else begin
            accumulate = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // A completing sample restarts the frame in the same cycle so back-to-back input loses nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r <= '0;
      cnt   <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else begin
      if (start || complete) begin
        len_r <= len_sel;
      end
      if (start || complete || discard) begin
        cnt   <= '0;
        acc_i <= '0;
        acc_q <= '0;
      end else if (accumulate) begin
        cnt   <= cnt + {{(LEN_W-1){1'b0}}, 1'b1};
        acc_i <= sum_i;
        acc_q <= sum_q;
      end
    end
  end

`ifdef DDC_ACCUM_FRAME_SEQ_EN
  logic [31:0] seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= '0;
    end else if (complete) begin
      seq <= seq + 32'd1;
    end
  end
`endif

  logic [FW-1:0] push_data;
`ifdef DDC_ACCUM_FRAME_SEQ_EN
  assign push_data = {seq, sum_q, sum_i};
`else
  assign push_data = {sum_q, sum_i};
`endif

  // Handshake: a beat transfers on a rising edge where m_axis_tvalid and m_axis_tready are both 1;
  // while tvalid=1 and tready=0 the head entry, and therefore tdata/tuser, cannot change.
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign full    = (fill == (AW+1)'(FIFO_DEPTH));
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign push_ok = complete && (!full || pop);
  assign drop    = complete && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok, pop})
        2'b10:   fill <= fill + {{AW{1'b0}}, 1'b1};
        2'b01:   fill <= fill - {{AW{1'b0}}, 1'b1};
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Stale FIFO contents are masked so the bus reads zero whenever nothing is offered.
  assign m_axis_tvalid = (fill != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr][2*ACC_W-1:0] : '0;
`ifdef DDC_ACCUM_FRAME_SEQ_EN
  assign m_axis_tuser  = m_axis_tvalid ? mem[rd_ptr][FW-1:2*ACC_W] : '0;
`endif

endmodule

// File: tb/tb_ddc_accum.sv
// Directed bench for ddc_accum: one task per scenario, expected beats queued from hand-computed sums.
module tb_ddc_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] acc_len;
  logic        valid_in;
  logic [63:0] data_in;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [95:0] m_axis_tdata;
  logic        overflow;
  logic [15:0] drop_cnt;
`ifdef DDC_ACCUM_FRAME_SEQ_EN
  logic [31:0] m_axis_tuser;
`endif

  int total = 0;
  int bad   = 0;
  logic [95:0] exp_q[$];
  logic [31:0] exp_u[$];

  always #5 clk = ~clk;

  ddc_accum dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .acc_len       (acc_len),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
`ifdef DDC_ACCUM_FRAME_SEQ_EN
    .m_axis_tuser  (m_axis_tuser),
`endif
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  function automatic logic [63:0] smp(input logic [31:0] i, input logic [31:0] q);
    return {q, i};
  endfunction

  function automatic logic [95:0] mk(input logic [47:0] i, input logic [47:0] q);
    return {q, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; valid_in = 1'b0; m_axis_tready = 1'b0;
    data_in = '0; acc_len = 16'd1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_u.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; valid_in = 1'b0; m_axis_tready = 1'b0;
    data_in = '0; acc_len = 16'd1;
    tick(); tick();
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    total++; if (m_axis_tdata !== 96'd0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    acc_len = 16'd4; en = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      valid_in = 1'b1; data_in = smp(32'(k), 32'(-k));
      tick();
      if (k == 3) begin
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL basic_early got=%b exp=0", m_axis_tvalid); end
      end
    end
    valid_in = 1'b0;
    total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL basic_tvalid got=%b exp=1", m_axis_tvalid); end
    total++;
    if (m_axis_tdata !== mk(48'd10, 48'hFFFF_FFFF_FFF6)) begin
      bad++; $display("FAIL basic_tdata got=%h exp=%h", m_axis_tdata, mk(48'd10, 48'hFFFF_FFFF_FFF6));
    end
`ifdef DDC_ACCUM_FRAME_SEQ_EN
    total++; if (m_axis_tuser !== 32'd0) begin bad++; $display("FAIL basic_tuser got=%0d exp=0", m_axis_tuser); end
`endif
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL basic_popped got=%b exp=0", m_axis_tvalid); end
    repeat (5) tick();
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL basic_extra_beat got=%b exp=0", m_axis_tvalid); end
    en = 1'b0;
  endtask

  task automatic test_len_zero();
    do_reset();
    acc_len = 16'd0; en = 1'b1;
    tick();
    valid_in = 1'b1; data_in = smp(32'd7, 32'd3);
    tick();
    valid_in = 1'b0;
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mk(48'd7, 48'd3)) begin
      bad++; $display("FAIL len0_first got valid=%b data=%h exp=%h", m_axis_tvalid, m_axis_tdata, mk(48'd7, 48'd3));
    end
    m_axis_tready = 1'b1;
    valid_in = 1'b1; data_in = smp(32'd9, 32'd0);
    tick();
    valid_in = 1'b0;
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mk(48'd9, 48'd0)) begin
      bad++; $display("FAIL len0_second got valid=%b data=%h exp=%h", m_axis_tvalid, m_axis_tdata, mk(48'd9, 48'd0));
    end
    tick();
    m_axis_tready = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_overflow();
    int wait_n;
    do_reset();
    acc_len = 16'd1; en = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      valid_in = 1'b1; data_in = smp(32'(k), 32'd0);
      tick();
    end
    valid_in = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(mk(48'(k), 48'd0));
      exp_u.push_back(32'(k - 1));
    end
    m_axis_tready = 1'b1;
    while (exp_q.size() != 0) begin
      wait_n = 0;
      while (m_axis_tvalid !== 1'b1 && wait_n < 20) begin tick(); wait_n++; end
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[0]) begin
        bad++; $display("FAIL ovf_beat got valid=%b data=%h exp=%h", m_axis_tvalid, m_axis_tdata, exp_q[0]);
      end
`ifdef DDC_ACCUM_FRAME_SEQ_EN
      total++; if (m_axis_tuser !== exp_u[0]) begin bad++; $display("FAIL ovf_tuser got=%0d exp=%0d", m_axis_tuser, exp_u[0]); end
`endif
      void'(exp_q.pop_front());
      void'(exp_u.pop_front());
      tick();
    end
    m_axis_tready = 1'b0;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", m_axis_tvalid); end
    total++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_sticky got=%b/%0d exp=1/2", overflow, drop_cnt); end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    acc_len = 16'd2; en = 1'b1;
    tick();
    repeat (2) begin valid_in = 1'b1; data_in = smp(32'h8000_0000, 32'd0); tick(); end
    valid_in = 1'b0;
    total++;
    if (m_axis_tdata !== mk(48'hFFFF_0000_0000, 48'd0)) begin
      bad++; $display("FAIL wrap_neg got=%h exp=%h", m_axis_tdata, mk(48'hFFFF_0000_0000, 48'd0));
    end
    m_axis_tready = 1'b1; tick(); m_axis_tready = 1'b0;
    repeat (2) begin valid_in = 1'b1; data_in = smp(32'h7FFF_FFFF, 32'h8000_0000); tick(); end
    valid_in = 1'b0;
    total++;
    if (m_axis_tdata !== mk(48'h0000_FFFF_FFFE, 48'hFFFF_0000_0000)) begin
      bad++; $display("FAIL wrap_pos got=%h exp=%h", m_axis_tdata, mk(48'h0000_FFFF_FFFE, 48'hFFFF_0000_0000));
    end
    m_axis_tready = 1'b1; tick(); m_axis_tready = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int wait_n;
    do_reset();
    acc_len = 16'd2; en = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      valid_in = 1'b1; data_in = smp(32'(k), 32'(2 * k));
      tick();
      if (k == 1) acc_len = 16'd3;
    end
    valid_in = 1'b0;
    exp_q.push_back(mk(48'd3, 48'd6));   exp_u.push_back(32'd0);
    exp_q.push_back(mk(48'd12, 48'd24)); exp_u.push_back(32'd1);
    exp_q.push_back(mk(48'd21, 48'd42)); exp_u.push_back(32'd2);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
    m_axis_tready = 1'b1;
    while (exp_q.size() != 0) begin
      wait_n = 0;
      while (m_axis_tvalid !== 1'b1 && wait_n < 20) begin tick(); wait_n++; end
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[0]) begin
        bad++; $display("FAIL b2b_beat got valid=%b data=%h exp=%h", m_axis_tvalid, m_axis_tdata, exp_q[0]);
      end
`ifdef DDC_ACCUM_FRAME_SEQ_EN
      total++; if (m_axis_tuser !== exp_u[0]) begin bad++; $display("FAIL b2b_tuser got=%0d exp=%0d", m_axis_tuser, exp_u[0]); end
`endif
      void'(exp_q.pop_front());
      void'(exp_u.pop_front());
      tick();
    end
    m_axis_tready = 1'b0;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", m_axis_tvalid); end
    en = 1'b0;
  endtask

  task automatic test_full_pop();
    int wait_n;
    do_reset();
    acc_len = 16'd4; en = 1'b1;
    tick();
    repeat (16) begin valid_in = 1'b1; data_in = smp(32'd1, 32'd0); tick(); end
    for (int s = 0; s < 4; s++) begin
      valid_in = 1'b1; data_in = smp(32'd2, 32'd0);
      if (s == 3) m_axis_tready = 1'b1;
      tick();
    end
    valid_in = 1'b0; m_axis_tready = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_overflow got=%b exp=0", overflow); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL fullpop_drop_cnt got=%0d exp=0", drop_cnt); end
    for (int k = 1; k <= 3; k++) begin exp_q.push_back(mk(48'd4, 48'd0)); exp_u.push_back(32'(k)); end
    exp_q.push_back(mk(48'd8, 48'd0)); exp_u.push_back(32'd4);
    m_axis_tready = 1'b1;
    while (exp_q.size() != 0) begin
      wait_n = 0;
      while (m_axis_tvalid !== 1'b1 && wait_n < 20) begin tick(); wait_n++; end
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[0]) begin
        bad++; $display("FAIL fullpop_beat got valid=%b data=%h exp=%h", m_axis_tvalid, m_axis_tdata, exp_q[0]);
      end
`ifdef DDC_ACCUM_FRAME_SEQ_EN
      total++; if (m_axis_tuser !== exp_u[0]) begin bad++; $display("FAIL fullpop_tuser got=%0d exp=%0d", m_axis_tuser, exp_u[0]); end
`endif
      void'(exp_q.pop_front());
      void'(exp_u.pop_front());
      tick();
    end
    m_axis_tready = 1'b0;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b exp=0", m_axis_tvalid); end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    do_reset();
    acc_len = 16'd8; en = 1'b1;
    tick();
    repeat (5) begin valid_in = 1'b1; data_in = smp(32'd1, 32'd0); tick(); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL endrop_partial got=%b exp=0", m_axis_tvalid); end
    en = 1'b0; valid_in = 1'b1; data_in = smp(32'd100, 32'd0);
    tick();
    valid_in = 1'b0;
    tick();
    en = 1'b1;
    tick();
    repeat (8) begin valid_in = 1'b1; data_in = smp(32'd1, 32'd0); tick(); end
    valid_in = 1'b0;
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mk(48'd8, 48'd0)) begin
      bad++; $display("FAIL endrop_beat got valid=%b data=%h exp=%h", m_axis_tvalid, m_axis_tdata, mk(48'd8, 48'd0));
    end
`ifdef DDC_ACCUM_FRAME_SEQ_EN
    total++; if (m_axis_tuser !== 32'd0) begin bad++; $display("FAIL endrop_tuser got=%0d exp=0", m_axis_tuser); end
`endif
    m_axis_tready = 1'b1;
    tick();
    repeat (4) tick();
    m_axis_tready = 1'b0;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL endrop_single got=%b exp=0", m_axis_tvalid); end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    acc_len = 16'd1; en = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin valid_in = 1'b1; data_in = smp(32'(k), 32'd0); tick(); end
    acc_len = 16'd4;
    repeat (2) begin valid_in = 1'b1; data_in = smp(32'd100, 32'd0); tick(); end
    total++; if (overflow !== 1'b1 || m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got ovf=%b tvalid=%b exp=1/1", overflow, m_axis_tvalid); end
    rst = 1'b1; valid_in = 1'b1; data_in = smp(32'd50, 32'd0);
    tick();
    rst = 1'b0;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
    total++; if (m_axis_tdata !== 96'd0) begin bad++; $display("FAIL rstmid_tdata got=%h exp=0", m_axis_tdata); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_drop_cnt got=%0d exp=0", drop_cnt); end
    tick();
    repeat (4) begin valid_in = 1'b1; data_in = smp(32'd3, 32'hFFFF_FFFF); tick(); end
    valid_in = 1'b0;
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mk(48'd12, 48'hFFFF_FFFF_FFFC)) begin
      bad++; $display("FAIL rstmid_beat got valid=%b data=%h exp=%h", m_axis_tvalid, m_axis_tdata, mk(48'd12, 48'hFFFF_FFFF_FFFC));
    end
`ifdef DDC_ACCUM_FRAME_SEQ_EN
    total++; if (m_axis_tuser !== 32'd0) begin bad++; $display("FAIL rstmid_tuser got=%0d exp=0", m_axis_tuser); end
`endif
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_empty got=%b exp=0", m_axis_tvalid); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_full_pop();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
